// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poller.
// States, register map and control/status bit positions.
package nes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO
  } nes_state_e;

  localparam logic [3:0] REG_BUTTONS = 4'd0;
  localparam logic [3:0] REG_CTRL    = 4'd1;

  localparam int CTRL_START   = 0;
  localparam int CTRL_POLL_EN = 1;
  localparam int CTRL_CLR_CHG = 7;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_POLL_EN = 1;
  localparam int STAT_CHANGED = 7;

  localparam logic [2:0] LAST_BIT = 3'd7;

  function automatic logic [7:0] ctrl_status(
    input logic changed,
    input logic poll_en,
    input logic busy
  );
    logic [7:0] s;
    s = 8'h00;
    s[STAT_CHANGED] = changed;
    s[STAT_POLL_EN] = poll_en;
    s[STAT_BUSY]    = busy;
    return s;
  endfunction

endpackage

// File: rtl/nes_tick_gen.sv
// Half-phase timer for the NES bus: pulses tick_o on the last
// cycle of every CLK_DIV-cycle phase while enabled.
module nes_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nes_poll_ctrl.sv
// NES controller poller with TinyQV byte-register interface:
// latch, 7 shift pulses, 8-bit button capture, optional auto-poll.
module nes_poll_ctrl
  import nes_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nes_data_i,
  output logic       nes_latch_o,
  output logic       nes_clk_o,
  input  logic [3:0] address,
  input  logic [7:0] data_in,
  input  logic       data_write,
  output logic [7:0] data_out,
  output logic       valid_o
);

  localparam int TW = $clog2(POLL_CYCLES);

  nes_state_e state_q, state_d;
  logic          half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          changed_q, changed_d;
  logic          poll_en_q, poll_en_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          latch_q, latch_d;
  logic          nclk_q, nclk_d;
  logic          valid_q, valid_d;

  logic tick;
  logic idle;
  logic wr_ctrl;
  logic poll_fire;
  logic start;
  logic set_chg;
  logic sample;
  logic unused_data_bits;

  assign unused_data_bits = ^data_in[6:2];

  assign idle      = (state_q == IDLE);
  assign wr_ctrl   = data_write && (address == REG_CTRL);
  assign poll_fire = poll_en_q && idle &&
                     (timer_q == TW'(POLL_CYCLES - 1));
  assign start     = idle &&
                     ((wr_ctrl && data_in[CTRL_START]) || poll_fire);
  // Controller drives its shift output low for a pressed button.
  assign sample    = ~nes_data_i;

  nes_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (!idle),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    set_chg   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
          half_d  = 1'b0;
        end
      end
      LATCH: begin
        if (tick) begin
          if (half_q) begin
            shift_d[0] = sample;
            bit_d      = 3'd1;
            state_d    = CLK_HI;
          end else begin
            half_d = 1'b1;
          end
        end
      end
      CLK_HI: begin
        if (tick) begin
          shift_d[bit_q] = sample;
          state_d        = CLK_LO;
        end
      end
      CLK_LO: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d   = IDLE;
            buttons_d = shift_q;
            valid_d   = 1'b1;
            set_chg   = (shift_q != buttons_q);
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = CLK_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    latch_d = (state_d == LATCH);
    nclk_d  = (state_d == CLK_HI);

    // A new difference outranks a software clear in the same cycle.
    changed_d = changed_q;
    if (set_chg) begin
      changed_d = 1'b1;
    end else if (wr_ctrl && data_in[CTRL_CLR_CHG]) begin
      changed_d = 1'b0;
    end

    poll_en_d = poll_en_q;
    if (wr_ctrl) begin
      poll_en_d = data_in[CTRL_POLL_EN];
    end

    timer_d = timer_q;
    if (!poll_en_q || start) begin
      timer_d = '0;
    end else if (idle) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      half_q    <= 1'b0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      buttons_q <= 8'h00;
      changed_q <= 1'b0;
      poll_en_q <= 1'b0;
      timer_q   <= '0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      changed_q <= changed_d;
      poll_en_q <= poll_en_d;
      timer_q   <= timer_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      valid_q   <= valid_d;
    end
  end

  assign nes_latch_o = latch_q;
  assign nes_clk_o   = nclk_q;
  assign valid_o     = valid_q;

  always_comb begin
    data_out = 8'h00;
    unique case (1'b1)
      (address == REG_BUTTONS): data_out = buttons_q;
      (address == REG_CTRL):
        data_out = ctrl_status(changed_q, poll_en_q, !idle);
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_nes_poll_ctrl.sv
// Bench for nes_poll_ctrl: 4021 shift-register model, cycle-position
// reference model, per-cycle compare plus directed literal checks.
module tb_nes_poll_ctrl;

  localparam int DIV  = 4;
  localparam int POLL = 256;
  localparam int SCAN = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nes_data_i;
  logic       nes_latch_o;
  logic       nes_clk_o;
  logic [3:0] address = 4'd0;
  logic [7:0] data_in = 8'h00;
  logic       data_write = 1'b0;
  logic [7:0] data_out;
  logic       valid_o;

  always #5 clk = ~clk;

  nes_poll_ctrl #(
    .CLK_DIV(DIV),
    .POLL_CYCLES(POLL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .nes_data_i (nes_data_i),
    .nes_latch_o(nes_latch_o),
    .nes_clk_o  (nes_clk_o),
    .address    (address),
    .data_in    (data_in),
    .data_write (data_write),
    .data_out   (data_out),
    .valid_o    (valid_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // 4021 model: parallel load while latched, shift on nes_clk rise.
  logic [7:0] pressed = 8'h00;
  int  sh_idx = 0;
  logic sh_prev = 1'b0;
  assign nes_data_i = (sh_idx < 8) ? ~pressed[sh_idx] : 1'b0;

  always @(posedge clk) begin
    if (nes_latch_o) sh_idx <= 0;
    else if (nes_clk_o && !sh_prev) sh_idx <= sh_idx + 1;
    sh_prev <= nes_clk_o;
  end

  // Reference model: position within a scan, -1 when idle.
  int         m_n = -1;
  int         m_tmr = 0;
  logic [7:0] m_btn = 8'h00;
  logic [7:0] m_snap = 8'h00;
  bit m_chg, m_pen, m_valid, m_busy, m_wr1, m_start, m_set;

  always @(posedge clk) begin
    if (rst) begin
      m_n = -1; m_tmr = 0; m_btn = 8'h00;
      m_chg = 0; m_pen = 0; m_valid = 0;
    end else begin
      m_busy  = (m_n >= 0) && (m_n < SCAN);
      m_wr1   = data_write && (address == 4'd1);
      m_start = !m_busy && ((m_wr1 && data_in[0]) ||
                            (m_pen && m_tmr == POLL - 1));
      m_set   = 0;
      m_valid = 0;
      if (m_busy) begin
        m_n++;
        if (m_n == SCAN) begin
          m_valid = 1;
          m_set   = (m_snap != m_btn);
          m_btn   = m_snap;
        end
      end else if (m_start) begin
        m_n = 0;
        m_snap = pressed;
      end else begin
        m_n = -1;
      end
      if (!m_pen || m_start) m_tmr = 0;
      else if (!m_busy) m_tmr++;
      if (m_set) m_chg = 1;
      else if (m_wr1 && data_in[7]) m_chg = 0;
      if (m_wr1) m_pen = data_in[1];
    end
  end

  // Per-cycle compare and event monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   chk_en = 0;
  int   latch_cnt = 0, latch_hi = 0, clk_rise = 0, valid_cnt = 0;
  int   last_valid_cyc = 0;
  int   lat_q[$];
  logic p_latch = 0, p_nclk = 0;
  bit   e_busy, e_latch, e_nclk;
  logic [7:0] e_dout;

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      e_busy  = (m_n >= 0) && (m_n < SCAN);
      e_latch = (m_n >= 0) && (m_n < 2 * DIV);
      e_nclk  = (m_n >= 2 * DIV) && (m_n < SCAN - DIV) &&
                (((m_n - 2 * DIV) % (2 * DIV)) < DIV);
      if (address == 4'd0) e_dout = m_btn;
      else if (address == 4'd1)
        e_dout = {m_chg, 5'b0, m_pen, e_busy};
      else e_dout = 8'h00;
      chk("cyc_latch", nes_latch_o, e_latch);
      chk("cyc_nclk", nes_clk_o, e_nclk);
      chk("cyc_valid", valid_o, m_valid);
      chk("cyc_dout", data_out, e_dout);
    end
    if (nes_latch_o && !p_latch) begin
      latch_cnt++;
      lat_q.push_back(cyc);
    end
    if (nes_latch_o) latch_hi++;
    if (nes_clk_o && !p_nclk) clk_rise++;
    if (valid_o) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    p_latch = nes_latch_o;
    p_nclk  = nes_clk_o;
  end

  int wr_cyc = 0;

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] e,
                        input string nm);
    address = a;
    #1;
    chk(nm, data_out, e);
  endtask

  task automatic zero();
    latch_cnt = 0; latch_hi = 0; clk_rise = 0; valid_cnt = 0;
    lat_q.delete();
  endtask

  task automatic wait_valid(input int max, input string nm);
    int v0;
    int k;
    v0 = valid_cnt;
    k = 0;
    while (valid_cnt == v0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(nm, (valid_cnt > v0), 1);
    repeat (2) @(negedge clk);
  endtask

  int w0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_latch", nes_latch_o, 0);
    chk("rst_nclk", nes_clk_o, 0);
    chk("rst_valid", valid_o, 0);
    rd_chk(4'd0, 8'h00, "rst_reg0");
    rd_chk(4'd1, 8'h00, "rst_reg1");
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);

    // Basic scan of 0x5A.
    pressed = 8'h5A;
    zero();
    wr(4'd1, 8'h01);
    w0 = wr_cyc;
    wait_valid(200, "t1_timeout");
    chk("t1_latch_n", latch_cnt, 1);
    chk("t1_latch_len", latch_hi, 8);
    chk("t1_pulses", clk_rise, 7);
    chk("t1_latch_at", lat_q[0] - w0, 0);
    chk("t1_valid_at", last_valid_cyc - w0, 64);
    rd_chk(4'd0, 8'h5A, "t1_reg0");
    rd_chk(4'd1, 8'h80, "t1_reg1");

    // Clear changed, rescan identical data.
    wr(4'd1, 8'h80);
    rd_chk(4'd1, 8'h00, "t2_cleared");
    zero();
    wr(4'd1, 8'h01);
    wait_valid(200, "t2_timeout");
    rd_chk(4'd1, 8'h00, "t2_reg1");
    rd_chk(4'd0, 8'h5A, "t2_reg0");
    chk("t2_valid_n", valid_cnt, 1);

    // Start request while busy is dropped.
    zero();
    wr(4'd1, 8'h01);
    repeat (20) @(negedge clk);
    wr(4'd1, 8'h01);
    repeat (120) @(negedge clk);
    chk("t3_latch_n", latch_cnt, 1);
    chk("t3_valid_n", valid_cnt, 1);

    // Auto-poll every POLL+SCAN cycles, then disable.
    zero();
    wr(4'd1, 8'h02);
    w0 = wr_cyc;
    repeat (1000) @(negedge clk);
    chk("t4_scans", latch_cnt, 3);
    if (lat_q.size() >= 3) begin
      chk("t4_first", lat_q[0] - w0, 256);
      chk("t4_period1", lat_q[1] - lat_q[0], 320);
      chk("t4_period2", lat_q[2] - lat_q[1], 320);
    end else begin
      chk("t4_scan_list", lat_q.size(), 3);
    end
    wr(4'd1, 8'h00);
    rd_chk(4'd1, 8'h00, "t4_reg1_off");
    zero();
    repeat (700) @(negedge clk);
    chk("t4_no_scans", latch_cnt, 0);

    // Completion coincides with a clear: set wins.
    pressed = 8'hC3;
    zero();
    wr(4'd1, 8'h01);
    repeat (63) @(negedge clk);
    wr(4'd1, 8'h80);
    repeat (2) @(negedge clk);
    chk("t5_valid_n", valid_cnt, 1);
    rd_chk(4'd1, 8'h80, "t5_reg1");
    rd_chk(4'd0, 8'hC3, "t5_reg0");

    // Reset at cycle 30 of a scan.
    pressed = 8'h3C;
    zero();
    wr(4'd1, 8'h01);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_latch", nes_latch_o, 0);
    chk("t6_nclk", nes_clk_o, 0);
    chk("t6_valid", valid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6_no_valid", valid_cnt, 0);
    rd_chk(4'd0, 8'h00, "t6_reg0");
    rd_chk(4'd1, 8'h00, "t6_reg1");

    // Unmapped address: reads zero, writes ignored.
    zero();
    wr(4'd2, 8'h03);
    repeat (20) @(negedge clk);
    chk("t7_no_scan", latch_cnt, 0);
    rd_chk(4'd2, 8'h00, "t7_reg2");
    rd_chk(4'd15, 8'h00, "t7_reg15");

    // Fresh scan after reset.
    wr(4'd1, 8'h01);
    wait_valid(200, "t8_timeout");
    rd_chk(4'd0, 8'h3C, "t8_reg0");
    rd_chk(4'd1, 8'h80, "t8_reg1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_poll_ctrl.md
NES_POLL_CTRL -- requirements
Module: nes_poll_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per half-phase of the NES bus (2..255).
REQ-002 SHALL have parameter POLL_CYCLES, default 16384: auto-poll interval in clk cycles, 256 or more.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port nes_data_i, input, 1: serial data from the controller, active-low (0 = pressed).
REQ-006 SHALL have port nes_latch_o, output, 1: latch strobe to the controller.
REQ-007 SHALL have port nes_clk_o, output, 1: shift clock to the controller.
REQ-008 SHALL have port address, input, 4: register address from the TinyQV byte-peripheral bus.
REQ-009 SHALL have port data_in, input, 8: write data.
REQ-010 SHALL have port data_write, input, 1: single-cycle write strobe.
REQ-011 SHALL have port data_out, output, 8: combinational read data for the current address.
REQ-012 SHALL have port valid_o, output, 1: one-cycle pulse when a new button byte is committed.

Function
REQ-013 SHALL implement the FSM states IDLE, LATCH, CLK_HI, CLK_LO.
REQ-014 IDLE SHALL drive nes_latch_o=0 and nes_clk_o=0; on a start request it SHALL go to LATCH on the next cycle.
REQ-015 A start request SHALL be either a write to address 1 with data_in[0]=1, or the poll timer expiring while poll_en=1.
REQ-016 LATCH SHALL hold nes_latch_o=1 for exactly 2*CLK_DIV cycles, then sample the inverted nes_data_i into shift bit 0 and go to CLK_HI.
REQ-017 CLK_HI SHALL hold nes_clk_o=1 for CLK_DIV cycles; on its last cycle it SHALL sample the inverted nes_data_i into the next shift bit (1..7).
REQ-018 CLK_LO SHALL hold nes_clk_o=0 for CLK_DIV cycles, then return to CLK_HI; after the 7th pulse it SHALL instead return to IDLE.
REQ-019 A scan SHALL therefore be 16*CLK_DIV cycles long, with exactly 7 nes_clk_o pulses.
REQ-020 On the cycle the FSM returns to IDLE, buttons SHALL be loaded from the shift register and valid_o SHALL pulse for that cycle.
REQ-021 buttons bit0 SHALL be A, then B, Select, Start, Up, Down, Left, Right; 1 = pressed.
REQ-022 Also on that cycle, the changed flag SHALL be set if the new byte differs from the previous buttons value.
REQ-023 A start request while busy SHALL be ignored; no queuing.
REQ-024 The poll timer SHALL count only while poll_en=1 and IDLE; it SHALL reset to 0 on scan start or when poll_en=0.
REQ-025 The poll timer SHALL expire when the count reaches POLL_CYCLES-1.
REQ-026 Register 0 (read-only) SHALL return buttons.
REQ-027 Register 1 read SHALL return {changed, 5'b0, poll_en, busy}; busy = FSM not IDLE.
REQ-028 Register 1 write: bit1 SHALL load poll_en; bit7=1 SHALL clear changed.
REQ-029 If a clear of changed and a set of changed occur in the same cycle, the set SHALL win.
REQ-030 Other addresses SHALL read 0x00; writes to them SHALL be ignored.
REQ-031 A partial scan SHALL never alter buttons.

Reset
REQ-032 While rst=1, the block SHALL go to IDLE and clear buttons, shift register, changed, poll_en, the poll timer and the phase counter.
REQ-033 Reset SHALL force nes_latch_o=0, nes_clk_o=0 and valid_o=0 on the next edge, including mid-scan.

Structure
REQ-034 Package nes_pkg SHALL hold the state enum, the register address constants (REG_BUTTONS=0, REG_CTRL=1) and the control bit index constants.
REQ-035 The phase/half-period counter SHALL be one sub-module, nes_tick_gen, which emits a phase-end pulse every CLK_DIV cycles while enabled.

Verification (CLK_DIV=4)
REQ-036 Write 0x01 to address 1 with nes_data_i modeled as a 4021 holding 0x5A inverted: latch high 8 cycles, 7 clk pulses, valid_o at cycle 64 after accept, reg0 reads 0x5A, reg1 bit7=1.
REQ-037 Repeat the scan with the same data, write 0x80 before it: changed stays 0 and reg0 stays 0x5A.
REQ-038 Write start during an active scan: no second scan, total latch pulses = 1.
REQ-039 poll_en=1 with POLL_CYCLES=256: scans start every 256+64 cycles; after writing 0x00, no further scans.
REQ-040 Assert rst at cycle 30 of a scan: outputs low next edge, reg0=0x00, no valid_o.
REQ-041 Scan completion coincides with a write of 0x80: changed reads 1 afterwards.
